docita_exec_unit: RTL and testbench
===================================

DOCITA_EXEC_UNIT -- requirements
Module: docita_exec_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset (iCLK, iRESET), and no other clock or reset.
REQ-002 iCLK  in  1  system clock; all state changes on the rising edge.
REQ-003 iRESET  in  1  synchronous reset, active-high.
REQ-004 iINST  in  12  instruction word from memory; sampled in FETCH.
REQ-005 iOP1, iOP2  in  12 each  register values of oRS1 and oRS2 from the external GPR; valid during EXEC.
REQ-006 iNPC  in  12  PC+1 of the current instruction.
REQ-007 oFETCH, oDECODE, oEXEC, oWB  out  1 each  one-hot phase strobes.
REQ-008 oRS1, oRS2, oRD  out  3 each  register selects; oEN_DEST  out  1  destination write enable.
REQ-009 oIS_ALU, oIS_IMM, oIS_LOAD, oIS_STORE, oIS_JUMP, oIS_ABS  out  1 each  decoded class flags.
REQ-010 oIMM  out  12  sign-extended literal; oALU_CTRL  out  4  ALU command.
REQ-011 oRES  out  12  ALU result; oNEG, oALL_ZEROn, oANY_POS  out  1 each  result flags.
REQ-012 oIS_TAKEN  out  1  branch taken; oTPC  out  12  jump/branch target.

Function
REQ-013 Phase FSM SHALL cycle FETCH->DECODE->EXEC->WB->FETCH, one clock per phase; exactly one strobe high outside reset.
REQ-014 IR SHALL load iINST on the clock edge that ends FETCH; decode outputs SHALL derive from IR and hold from DECODE through the following FETCH.
REQ-015 Encoding, octal digits [11:9]op [8:6]A [5:3]B [2:0]C.
REQ-016 op0 ALU-R: rd=rs1=A, rs2=B, oALU_CTRL={0,C}, EN_DEST=1.
REQ-017 op1 ADDI: rd=rs1=A, oIMM=sext([5:0]), IS_IMM=1, ALU_CTRL=ADD, EN_DEST=1.
REQ-018 op2 LOAD: rd=A, address reg rs2=B, IS_LOAD=1, EN_DEST=1.
REQ-019 op3 STORE: data rs1=A, address rs2=B, IS_STORE=1, EN_DEST=0.
REQ-020 op4 LI: rd=A, oIMM=sext([5:0]), IS_IMM=1, ALU_CTRL=PASS2 (4'b1001), EN_DEST=1.
REQ-021 op5 BR: rs1=A, cond=[5:4] (00 zero, 01 nonzero, 10 positive, 11 negative), oIMM=sext([3:0]), ALU_CTRL=PASS1 (4'b1000), EN_DEST=0.
REQ-022 op6 JAL: rd=A (link), oIMM=sext([5:0]), IS_JUMP=1, IS_ABS=0, EN_DEST=1.
REQ-023 op7 JR: rd=A (link), rs2=B, IS_JUMP=1, IS_ABS=1, EN_DEST=1.
REQ-024 oIS_ALU SHALL be 1 for op0, op1, op4 and op5; 0 otherwise.
REQ-025 ALU func: 000 ADD, 001 SUB (OP1-OP2), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR logical, 111 SRA; shift amount OP2[3:0], amounts >=12 give 0 (SRA: all sign bits).
REQ-026 ALU operand 2 SHALL be oIMM when IS_IMM, else iOP2; arithmetic modulo 2^12, no carry out.
REQ-027 oRES and flags SHALL register on the edge ending EXEC and hold until the next EXEC ends; NEG=oRES[11], ALL_ZEROn=|oRES, ANY_POS=~oRES[11]&|oRES.
REQ-028 oIS_TAKEN SHALL be combinational, high only during EXEC of op5 when the combinational ALU result meets cond.
REQ-029 oTPC SHALL equal iOP2 when IS_ABS, else iNPC+oIMM modulo 2^12 (wrap 0o7777+1=0).
REQ-030 Unlisted ALU_CTRL codes SHALL yield 0.

Reset
REQ-031 While iRESET is high: all phase strobes, IR, oRES and all flags 0; oNEG=0, oALL_ZEROn=0, oANY_POS=0.
REQ-032 On the first edge with iRESET low, FSM SHALL enter FETCH; reset asserted in any phase SHALL abort the instruction with no result update.

Structure
REQ-033 Opcode, ALU_CTRL and condition constants SHALL reside in a shared package.
REQ-034 Sub-modules SHALL be alu (REQ-025..027, 030) and addr_gen (REQ-029); control FSM/decoder at top.

Verification
REQ-035 inst 0o0120, iOP1=5, iOP2=7 -> in WB oRES=0o0014, ALL_ZEROn=1, ANY_POS=1, oRD=1.
REQ-036 inst 0o0121, iOP1=iOP2=3 -> oRES=0, ALL_ZEROn=0, ANY_POS=0.
REQ-037 inst 0o1277, iOP1=0 -> oIMM=0o7777, oRES=0o7777, NEG=1.
REQ-038 inst 0o5316, iOP1=0, iNPC=0o0100 -> oIS_TAKEN=1 during EXEC only, oTPC=0o0076; with iOP1=1 oIS_TAKEN=0.
REQ-039 inst 0o7740, iOP2=0o1234 -> IS_JUMP=1, IS_ABS=1, oTPC=0o1234, oRD=7, EN_DEST=1.
REQ-040 iRESET high during EXEC -> next cycle all strobes 0, oRES=0; after release FETCH on the next cycle.

Source files
------------

// File: rtl/docita_exec_unit_pkg.sv
// Shared opcodes, ALU commands, branch conditions
// and phase encoding for the docita execution unit.
package docita_exec_unit_pkg;

  typedef enum logic [2:0] {
    OP_ALUR  = 3'o0,
    OP_ADDI  = 3'o1,
    OP_LOAD  = 3'o2,
    OP_STORE = 3'o3,
    OP_LI    = 3'o4,
    OP_BR    = 3'o5,
    OP_JAL   = 3'o6,
    OP_JR    = 3'o7
  } opcode_e;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SHL   = 4'b0101;
  localparam logic [3:0] ALU_SHR   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_PASS1 = 4'b1000;
  localparam logic [3:0] ALU_PASS2 = 4'b1001;

  typedef enum logic [1:0] {
    COND_ZERO = 2'b00,
    COND_NZ   = 2'b01,
    COND_POS  = 2'b10,
    COND_NEG  = 2'b11
  } cond_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_FETCH,
    PH_DECODE,
    PH_EXEC,
    PH_WB
  } phase_e;

  function automatic logic [11:0] sext6(
    input logic [5:0] v
  );
    return {{6{v[5]}}, v};
  endfunction

  function automatic logic [11:0] sext4(
    input logic [3:0] v
  );
    return {{8{v[3]}}, v};
  endfunction

endpackage

// File: rtl/docita_exec_unit_addr_gen.sv
// Jump/branch target: absolute register value
// or PC-relative offset, wrapping at 12 bits.
module docita_exec_unit_addr_gen (
  input  logic        is_abs_i,
  input  logic [11:0] npc_i,
  input  logic [11:0] imm_i,
  input  logic [11:0] op2_i,
  output logic [11:0] tpc_o
);

  assign tpc_o = is_abs_i ? op2_i
                          : (npc_i + imm_i);

endmodule

// File: rtl/docita_exec_unit_alu.sv
// 12-bit ALU with a result register loaded
// at the end of EXEC and derived result flags.
module docita_exec_unit_alu
  import docita_exec_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [3:0]  ctrl_i,
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] res_c_o,
  output logic [11:0] res_o,
  output logic        neg_o,
  output logic        nz_o,
  output logic        pos_o
);

  logic [11:0] res_d;
  logic [11:0] res_q;
  logic [3:0]  sh;
  logic        big;

  assign sh  = b_i[3:0];
  assign big = (sh >= 4'd12);

  // Combinational result; shifts of 12+ saturate
  always_comb begin
    res_d = '0;
    case (ctrl_i)
      ALU_ADD:   res_d = a_i + b_i;
      ALU_SUB:   res_d = a_i - b_i;
      ALU_AND:   res_d = a_i & b_i;
      ALU_OR:    res_d = a_i | b_i;
      ALU_XOR:   res_d = a_i ^ b_i;
      ALU_SHL:   res_d = big ? '0 : (a_i << sh);
      ALU_SHR:   res_d = big ? '0 : (a_i >> sh);
      ALU_SRA:   res_d = big ? {12{a_i[11]}}
                             : 12'($signed(a_i) >>> sh);
      ALU_PASS1: res_d = a_i;
      ALU_PASS2: res_d = b_i;
      default:   res_d = '0;
    endcase
  end

  // Result register, captured once per instruction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (load_i) begin
      res_q <= res_d;
    end
  end

  assign res_c_o = res_d;
  assign res_o   = res_q;
  assign neg_o   = res_q[11];
  assign nz_o    = |res_q;
  assign pos_o   = ~res_q[11] & (|res_q);

endmodule

// File: rtl/docita_exec_unit.sv
// Four-phase control FSM, instruction register
// and decoder driving the ALU and target unit.
module docita_exec_unit
  import docita_exec_unit_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [11:0] iINST,
  input  logic [11:0] iOP1,
  input  logic [11:0] iOP2,
  input  logic [11:0] iNPC,
  output logic        oFETCH,
  output logic        oDECODE,
  output logic        oEXEC,
  output logic        oWB,
  output logic [2:0]  oRS1,
  output logic [2:0]  oRS2,
  output logic [2:0]  oRD,
  output logic        oEN_DEST,
  output logic        oIS_ALU,
  output logic        oIS_IMM,
  output logic        oIS_LOAD,
  output logic        oIS_STORE,
  output logic        oIS_JUMP,
  output logic        oIS_ABS,
  output logic [11:0] oIMM,
  output logic [3:0]  oALU_CTRL,
  output logic [11:0] oRES,
  output logic        oNEG,
  output logic        oALL_ZEROn,
  output logic        oANY_POS,
  output logic        oIS_TAKEN,
  output logic [11:0] oTPC
);

  phase_e      state_q;
  phase_e      state_d;
  logic [11:0] ir_q;
  opcode_e     op;
  cond_e       cond;
  logic [11:0] alu_b;
  logic [11:0] alu_c;

  assign op   = opcode_e'(ir_q[11:9]);
  assign cond = cond_e'(ir_q[5:4]);

  // Phase register; reset parks in a strobe-free idle
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= PH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase sequencing, one clock per phase
  always_comb begin
    state_d = PH_FETCH;
    unique case (state_q)
      PH_IDLE:   state_d = PH_FETCH;
      PH_FETCH:  state_d = PH_DECODE;
      PH_DECODE: state_d = PH_EXEC;
      PH_EXEC:   state_d = PH_WB;
      PH_WB:     state_d = PH_FETCH;
      default:   state_d = PH_FETCH;
    endcase
  end

  assign oFETCH  = (state_q == PH_FETCH);
  assign oDECODE = (state_q == PH_DECODE);
  assign oEXEC   = (state_q == PH_EXEC);
  assign oWB     = (state_q == PH_WB);

  // Instruction register, loaded as FETCH ends
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      ir_q <= '0;
    end else if (oFETCH) begin
      ir_q <= iINST;
    end
  end

  assign oRS1 = ir_q[8:6];
  assign oRS2 = ir_q[5:3];
  assign oRD  = ir_q[8:6];

  // Instruction decoder
  always_comb begin
    oEN_DEST  = 1'b0;
    oIS_ALU   = 1'b0;
    oIS_IMM   = 1'b0;
    oIS_LOAD  = 1'b0;
    oIS_STORE = 1'b0;
    oIS_JUMP  = 1'b0;
    oIS_ABS   = 1'b0;
    oIMM      = '0;
    oALU_CTRL = ALU_ADD;
    unique case (op)
      OP_ALUR: begin
        oIS_ALU   = 1'b1;
        oEN_DEST  = 1'b1;
        oALU_CTRL = {1'b0, ir_q[2:0]};
      end
      OP_ADDI: begin
        oIS_ALU  = 1'b1;
        oIS_IMM  = 1'b1;
        oEN_DEST = 1'b1;
        oIMM     = sext6(ir_q[5:0]);
      end
      OP_LOAD: begin
        oIS_LOAD = 1'b1;
        oEN_DEST = 1'b1;
      end
      OP_STORE: begin
        oIS_STORE = 1'b1;
      end
      OP_LI: begin
        oIS_ALU   = 1'b1;
        oIS_IMM   = 1'b1;
        oEN_DEST  = 1'b1;
        oIMM      = sext6(ir_q[5:0]);
        oALU_CTRL = ALU_PASS2;
      end
      OP_BR: begin
        oIS_ALU   = 1'b1;
        oIMM      = sext4(ir_q[3:0]);
        oALU_CTRL = ALU_PASS1;
      end
      OP_JAL: begin
        oIS_JUMP = 1'b1;
        oEN_DEST = 1'b1;
        oIMM     = sext6(ir_q[5:0]);
      end
      OP_JR: begin
        oIS_JUMP = 1'b1;
        oIS_ABS  = 1'b1;
        oEN_DEST = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_b = oIS_IMM ? oIMM : iOP2;

  docita_exec_unit_alu u_alu (
    .clk_i   (iCLK),
    .rst_i   (iRESET),
    .load_i  (oEXEC),
    .ctrl_i  (oALU_CTRL),
    .a_i     (iOP1),
    .b_i     (alu_b),
    .res_c_o (alu_c),
    .res_o   (oRES),
    .neg_o   (oNEG),
    .nz_o    (oALL_ZEROn),
    .pos_o   (oANY_POS)
  );

  docita_exec_unit_addr_gen u_addr (
    .is_abs_i (oIS_ABS),
    .npc_i    (iNPC),
    .imm_i    (oIMM),
    .op2_i    (iOP2),
    .tpc_o    (oTPC)
  );

  // Branch decision on the live ALU result
  always_comb begin
    oIS_TAKEN = 1'b0;
    if (oEXEC && op == OP_BR) begin
      unique case (cond)
        COND_ZERO: oIS_TAKEN = ~|alu_c;
        COND_NZ:   oIS_TAKEN = |alu_c;
        COND_POS:  oIS_TAKEN = ~alu_c[11] & (|alu_c);
        COND_NEG:  oIS_TAKEN = alu_c[11];
        default:   oIS_TAKEN = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_docita_exec_unit.sv
// Bench for docita_exec_unit: directed cases
// plus random instructions against a model.
module tb_docita_exec_unit;

  typedef struct packed {
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic        en;
    logic        alu;
    logic        immf;
    logic        ld;
    logic        st;
    logic        jmp;
    logic        jabs;
    logic [11:0] imm;
    logic [3:0]  ctrl;
  } dec_t;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic [11:0] iINST, iOP1, iOP2, iNPC;
  logic        oFETCH, oDECODE, oEXEC, oWB;
  logic [2:0]  oRS1, oRS2, oRD;
  logic        oEN_DEST, oIS_ALU, oIS_IMM;
  logic        oIS_LOAD, oIS_STORE;
  logic        oIS_JUMP, oIS_ABS;
  logic [11:0] oIMM;
  logic [3:0]  oALU_CTRL;
  logic [11:0] oRES;
  logic        oNEG, oALL_ZEROn, oANY_POS;
  logic        oIS_TAKEN;
  logic [11:0] oTPC;

  int pass_cnt = 0;
  int total_cnt = 0;

  dec_t        d_obs, f_obs;
  logic        d_taken, e_taken, w_taken;
  logic [11:0] e_tpc, w_res;
  logic [2:0]  w_flags;
  logic [3:0]  e_ph;

  docita_exec_unit dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iINST(iINST), .iOP1(iOP1),
    .iOP2(iOP2), .iNPC(iNPC),
    .oFETCH(oFETCH), .oDECODE(oDECODE),
    .oEXEC(oEXEC), .oWB(oWB),
    .oRS1(oRS1), .oRS2(oRS2), .oRD(oRD),
    .oEN_DEST(oEN_DEST), .oIS_ALU(oIS_ALU),
    .oIS_IMM(oIS_IMM), .oIS_LOAD(oIS_LOAD),
    .oIS_STORE(oIS_STORE),
    .oIS_JUMP(oIS_JUMP), .oIS_ABS(oIS_ABS),
    .oIMM(oIMM), .oALU_CTRL(oALU_CTRL),
    .oRES(oRES), .oNEG(oNEG),
    .oALL_ZEROn(oALL_ZEROn),
    .oANY_POS(oANY_POS),
    .oIS_TAKEN(oIS_TAKEN), .oTPC(oTPC)
  );

  always #5 iCLK = ~iCLK;

  function automatic dec_t snap();
    dec_t s;
    s.rs1 = oRS1; s.rs2 = oRS2; s.rd = oRD;
    s.en = oEN_DEST; s.alu = oIS_ALU;
    s.immf = oIS_IMM; s.ld = oIS_LOAD;
    s.st = oIS_STORE; s.jmp = oIS_JUMP;
    s.jabs = oIS_ABS; s.imm = oIMM;
    s.ctrl = oALU_CTRL;
    return s;
  endfunction

  function automatic logic [3:0] strobes();
    return {oFETCH, oDECODE, oEXEC, oWB};
  endfunction

  // Reference decode from the encoding table
  function automatic dec_t m_dec(
    input logic [11:0] inst
  );
    dec_t e;
    int op, v6, v4;
    op = int'(inst[11:9]);
    v6 = int'(inst[5:0]);
    if (v6 >= 32) v6 -= 64;
    v4 = int'(inst[3:0]);
    if (v4 >= 8) v4 -= 16;
    e = '0;
    e.rs1 = inst[8:6];
    e.rs2 = inst[5:3];
    e.rd  = inst[8:6];
    case (op)
      0: begin
        e.alu = 1; e.en = 1;
        e.ctrl = 4'(int'(inst[2:0]));
      end
      1: begin
        e.alu = 1; e.immf = 1; e.en = 1;
        e.imm = 12'(v6 & 4095);
      end
      2: begin e.ld = 1; e.en = 1; end
      3: e.st = 1;
      4: begin
        e.alu = 1; e.immf = 1; e.en = 1;
        e.imm = 12'(v6 & 4095); e.ctrl = 9;
      end
      5: begin
        e.alu = 1; e.ctrl = 8;
        e.imm = 12'(v4 & 4095);
      end
      6: begin
        e.jmp = 1; e.en = 1;
        e.imm = 12'(v6 & 4095);
      end
      default: begin
        e.jmp = 1; e.jabs = 1; e.en = 1;
      end
    endcase
    return e;
  endfunction

  // Reference ALU using plain integer arithmetic
  function automatic logic [11:0] m_res(
    input dec_t e, input logic [11:0] a,
    input logic [11:0] b
  );
    int x, y, n, sx, r;
    x = int'(a);
    y = e.immf ? int'(e.imm) : int'(b);
    n = y % 16;
    sx = (x >= 2048) ? x - 4096 : x;
    case (int'(e.ctrl))
      0: r = x + y;
      1: r = x - y + 4096;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = x * (1 << n);
      6: r = x / (1 << n);
      7: r = sx >>> n;
      8: r = x;
      9: r = y;
      default: r = 0;
    endcase
    return 12'(r & 4095);
  endfunction

  function automatic logic m_taken(
    input logic [11:0] inst,
    input logic [11:0] r
  );
    int c;
    if (inst[11:9] != 3'o5) return 1'b0;
    c = int'(inst[5:4]);
    case (c)
      0: return r == 0;
      1: return r != 0;
      2: return r != 0 && r < 2048;
      default: return r >= 2048;
    endcase
  endfunction

  function automatic logic [11:0] m_tpc(
    input dec_t e, input logic [11:0] b,
    input logic [11:0] npc
  );
    if (e.jabs) return b;
    return 12'((int'(npc) + int'(e.imm)) % 4096);
  endfunction

  // Drives one instruction through all four phases
  task automatic issue(
    input logic [11:0] inst, input logic [11:0] a,
    input logic [11:0] b, input logic [11:0] npc
  );
    int n;
    n = 0;
    while (!oFETCH && n < 8) begin
      @(posedge iCLK); #1; n++;
    end
    if (!oFETCH) begin
      total_cnt++;
      $display("FAIL fetch_wait got %b want 1000",
               strobes());
    end
    iINST = inst; iOP1 = a; iOP2 = b; iNPC = npc;
    @(posedge iCLK); #1;
    iINST = 12'($urandom);
    d_obs = snap(); d_taken = oIS_TAKEN;
    @(posedge iCLK); #1;
    e_taken = oIS_TAKEN; e_tpc = oTPC;
    e_ph = strobes();
    @(posedge iCLK); #1;
    w_res = oRES; w_taken = oIS_TAKEN;
    w_flags = {oNEG, oALL_ZEROn, oANY_POS};
    @(posedge iCLK); #1;
    f_obs = snap();
  endtask

  task automatic test_reset();
    iRESET = 1'b1;
    iINST = '0; iOP1 = '0; iOP2 = '0; iNPC = '0;
    repeat (3) @(posedge iCLK);
    #1;
    total_cnt++;
    if (strobes() !== 4'b0000)
      $display("FAIL rst_strobes got %b want 0000",
               strobes());
    else pass_cnt++;
    total_cnt++;
    if (oRES !== 12'd0)
      $display("FAIL rst_res got %o want 0", oRES);
    else pass_cnt++;
    total_cnt++;
    if ({oNEG, oALL_ZEROn, oANY_POS} !== 3'b000)
      $display("FAIL rst_flags got %b want 000",
               {oNEG, oALL_ZEROn, oANY_POS});
    else pass_cnt++;
    iRESET = 1'b0;
    @(posedge iCLK); #1;
    total_cnt++;
    if (strobes() !== 4'b1000)
      $display("FAIL rst_release got %b want 1000",
               strobes());
    else pass_cnt++;
  endtask

  task automatic test_phases();
    logic [3:0] exp;
    for (int k = 0; k < 9; k++) begin
      exp = 4'b1000 >> (k % 4);
      total_cnt++;
      if (strobes() !== exp)
        $display("FAIL phase%0d got %b want %b",
                 k, strobes(), exp);
      else pass_cnt++;
      if (k < 8) begin
        @(posedge iCLK); #1;
      end
    end
  endtask

  task automatic test_alu_directed();
    issue(12'o0120, 12'd5, 12'd7, 12'd0);
    total_cnt++;
    if (w_res !== 12'o0014 || w_flags !== 3'b011)
      $display("FAIL add res=%o fl=%b want 0014 011",
               w_res, w_flags);
    else pass_cnt++;
    total_cnt++;
    if (d_obs.rd !== 3'd1 || d_obs.en !== 1'b1)
      $display("FAIL add_rd rd=%0d en=%b want 1 1",
               d_obs.rd, d_obs.en);
    else pass_cnt++;
    issue(12'o0121, 12'd3, 12'd3, 12'd0);
    total_cnt++;
    if (w_res !== 12'd0 || w_flags !== 3'b000)
      $display("FAIL sub res=%o fl=%b want 0 000",
               w_res, w_flags);
    else pass_cnt++;
    issue(12'o1277, 12'd0, 12'd0, 12'd0);
    total_cnt++;
    if (d_obs.imm !== 12'o7777)
      $display("FAIL addi_imm got %o want 7777",
               d_obs.imm);
    else pass_cnt++;
    total_cnt++;
    if (w_res !== 12'o7777 || w_flags !== 3'b110)
      $display("FAIL addi res=%o fl=%b want 7777 110",
               w_res, w_flags);
    else pass_cnt++;
    issue(12'o0127, 12'o4000, 12'd13, 12'd0);
    total_cnt++;
    if (w_res !== 12'o7777)
      $display("FAIL sra13 got %o want 7777", w_res);
    else pass_cnt++;
    issue(12'o0125, 12'd1, 12'd12, 12'd0);
    total_cnt++;
    if (w_res !== 12'd0)
      $display("FAIL shl12 got %o want 0", w_res);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    issue(12'o5316, 12'd0, 12'd0, 12'o0100);
    total_cnt++;
    if ({d_taken, e_taken, w_taken} !== 3'b010)
      $display("FAIL br_taken d/e/w=%b want 010",
               {d_taken, e_taken, w_taken});
    else pass_cnt++;
    total_cnt++;
    if (e_tpc !== 12'o0076)
      $display("FAIL br_tpc got %o want 0076", e_tpc);
    else pass_cnt++;
    issue(12'o5316, 12'd1, 12'd0, 12'o0100);
    total_cnt++;
    if (e_taken !== 1'b0)
      $display("FAIL br_not got %b want 0", e_taken);
    else pass_cnt++;
  endtask

  task automatic test_jump();
    issue(12'o7740, 12'd0, 12'o1234, 12'd0);
    total_cnt++;
    if ({d_obs.jmp, d_obs.jabs, d_obs.en} !== 3'b111)
      $display("FAIL jr_flags got %b want 111",
               {d_obs.jmp, d_obs.jabs, d_obs.en});
    else pass_cnt++;
    total_cnt++;
    if (e_tpc !== 12'o1234 || d_obs.rd !== 3'd7)
      $display("FAIL jr tpc=%o rd=%0d want 1234 7",
               e_tpc, d_obs.rd);
    else pass_cnt++;
    issue(12'o6001, 12'd0, 12'd0, 12'o7777);
    total_cnt++;
    if (e_tpc !== 12'd0)
      $display("FAIL jal_wrap got %o want 0", e_tpc);
    else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    issue(12'o0120, 12'd5, 12'd7, 12'd0);
    iINST = 12'o0121; iOP1 = 12'd9; iOP2 = 12'd1;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    total_cnt++;
    if (strobes() !== 4'b0010)
      $display("FAIL rx_exec got %b want 0010",
               strobes());
    else pass_cnt++;
    iRESET = 1'b1;
    @(posedge iCLK); #1;
    total_cnt++;
    if (strobes() !== 4'b0000 || oRES !== 12'd0)
      $display("FAIL rx_abort st=%b res=%o want 0 0",
               strobes(), oRES);
    else pass_cnt++;
    iRESET = 1'b0;
    @(posedge iCLK); #1;
    total_cnt++;
    if (strobes() !== 4'b1000 || oRES !== 12'd0)
      $display("FAIL rx_resume st=%b res=%o want 1000 0",
               strobes(), oRES);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [11:0] inst, a, b, npc, r;
    dec_t e;
    int op;
    for (int i = 0; i < 60; i++) begin
      inst = 12'($urandom); a = 12'($urandom);
      b = 12'($urandom); npc = 12'($urandom);
      op = int'(inst[11:9]);
      e = m_dec(inst);
      r = m_res(e, a, b);
      issue(inst, a, b, npc);
      total_cnt++;
      if ({d_obs.alu, d_obs.immf, d_obs.ld, d_obs.st,
           d_obs.jmp, d_obs.jabs, d_obs.en} !==
          {e.alu, e.immf, e.ld, e.st,
           e.jmp, e.jabs, e.en})
        $display("FAIL r_class i=%o got %b want %b",
          inst, {d_obs.alu, d_obs.immf, d_obs.ld,
          d_obs.st, d_obs.jmp, d_obs.jabs, d_obs.en},
          {e.alu, e.immf, e.ld, e.st,
           e.jmp, e.jabs, e.en});
      else pass_cnt++;
      total_cnt++;
      if ({f_obs.alu, f_obs.jmp, f_obs.en, f_obs.rd}
          !== {e.alu, e.jmp, e.en, e.rd})
        $display("FAIL r_hold i=%o got %b want %b",
          inst, {f_obs.alu, f_obs.jmp, f_obs.en,
          f_obs.rd}, {e.alu, e.jmp, e.en, e.rd});
      else pass_cnt++;
      if (e.en) begin
        total_cnt++;
        if (d_obs.rd !== e.rd)
          $display("FAIL r_rd i=%o got %0d want %0d",
                   inst, d_obs.rd, e.rd);
        else pass_cnt++;
      end
      if (op inside {0, 1, 3, 5}) begin
        total_cnt++;
        if (d_obs.rs1 !== e.rs1)
          $display("FAIL r_rs1 i=%o got %0d want %0d",
                   inst, d_obs.rs1, e.rs1);
        else pass_cnt++;
      end
      if (op inside {0, 2, 3, 7}) begin
        total_cnt++;
        if (d_obs.rs2 !== e.rs2)
          $display("FAIL r_rs2 i=%o got %0d want %0d",
                   inst, d_obs.rs2, e.rs2);
        else pass_cnt++;
      end
      if (op inside {1, 4, 5, 6}) begin
        total_cnt++;
        if (d_obs.imm !== e.imm)
          $display("FAIL r_imm i=%o got %o want %o",
                   inst, d_obs.imm, e.imm);
        else pass_cnt++;
      end
      if (e.alu) begin
        total_cnt++;
        if (d_obs.ctrl !== e.ctrl)
          $display("FAIL r_ctrl i=%o got %b want %b",
                   inst, d_obs.ctrl, e.ctrl);
        else pass_cnt++;
        total_cnt++;
        if (w_res !== r || w_flags !==
            {r >= 2048, r != 0, r != 0 && r < 2048})
          $display("FAIL r_res i=%o a=%o b=%o got %o/%b want %o",
                   inst, a, b, w_res, w_flags, r);
        else pass_cnt++;
      end
      total_cnt++;
      if ({d_taken, e_taken, w_taken} !==
          {1'b0, m_taken(inst, r), 1'b0})
        $display("FAIL r_taken i=%o got %b want %b",
          inst, {d_taken, e_taken, w_taken},
          {1'b0, m_taken(inst, r), 1'b0});
      else pass_cnt++;
      if (op inside {5, 6, 7}) begin
        total_cnt++;
        if (e_tpc !== m_tpc(e, b, npc))
          $display("FAIL r_tpc i=%o got %o want %o",
                   inst, e_tpc, m_tpc(e, b, npc));
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_phases();
    test_alu_directed();
    test_branch();
    test_jump();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
